// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding block: ALU operand forward
// selects and the stall-controller FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG    = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

endpackage

// File: rtl/forward_select.sv
// Forward-select for one EX-stage source operand. The EX/MEM result wins over
// MEM/WB, and a load still in EX/MEM has no data yet so it never forwards.
module forward_select
    import hazard_pkg::*;
#(
    parameter int N_BITS_REG = 5
) (
    input  logic [N_BITS_REG-1:0] src,
    input  logic [N_BITS_REG-1:0] rd_ex_mem,
    input  logic [N_BITS_REG-1:0] rd_mem_wb,
    input  logic                  reg_write_ex_mem,
    input  logic                  mem_read_ex_mem,
    input  logic                  reg_write_mem_wb,
    output fwd_t                  fwd
);

    always_comb begin
        fwd = FWD_REG;
        if (reg_write_ex_mem && !mem_read_ex_mem &&
            rd_ex_mem != '0 && rd_ex_mem == src) begin
            fwd = FWD_EX_MEM;
        end else if (reg_write_mem_wb && rd_mem_wb != '0 && rd_mem_wb == src) begin
            fwd = FWD_MEM_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard unit for the 5-stage pipeline: operand forwarding, load-use stall
// sequencing, data-memory wait freeze with sticky timeout, and stall statistics.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int N_BITS_REG = 5,
    parameter int N_SRC      = 2,
    parameter int LOAD_LAT   = 1,
    parameter int MAX_WAIT   = 255,
    parameter int N_BITS_CNT = 32
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [N_SRC*N_BITS_REG-1:0] i_src_id,
    input  logic [N_SRC-1:0]            i_src_valid_id,
    input  logic [N_SRC*N_BITS_REG-1:0] i_src_ex,
    input  logic [N_BITS_REG-1:0]       i_rd_ID_EX,
    input  logic [N_BITS_REG-1:0]       i_rd_EX_MEM,
    input  logic [N_BITS_REG-1:0]       i_rd_MEM_WB,
    input  logic                        i_regWrite_ID_EX,
    input  logic                        i_regWrite_EX_MEM,
    input  logic                        i_regWrite_MEM_WB,
    input  logic                        i_memRead_ID_EX,
    input  logic                        i_memRead_EX_MEM,
    input  logic                        i_memAccess_EX_MEM,
    input  logic                        i_mem_ready,
    input  logic                        i_flush,
    output logic [2*N_SRC-1:0]          o_forward,
    output logic                        o_stall,
    output logic                        o_bubble,
    output logic                        o_freeze,
    output logic                        o_mem_timeout,
    output logic [N_BITS_CNT-1:0]       o_stall_cycles
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int CNT_W  = 2;

    state_t              state, state_next, active_state;
    logic [CNT_W-1:0]    lu_cnt, lu_cnt_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;
    logic                src_hit, load_use, mem_stall;

    for (genvar k = 0; k < N_SRC; k++) begin : g_fwd
        fwd_t fwd_sel;
        forward_select #(.N_BITS_REG(N_BITS_REG)) u_forward_select (
            .src              (i_src_ex[k*N_BITS_REG +: N_BITS_REG]),
            .rd_ex_mem        (i_rd_EX_MEM),
            .rd_mem_wb        (i_rd_MEM_WB),
            .reg_write_ex_mem (i_regWrite_EX_MEM),
            .mem_read_ex_mem  (i_memRead_EX_MEM),
            .reg_write_mem_wb (i_regWrite_MEM_WB),
            .fwd              (fwd_sel)
        );
        assign o_forward[2*k +: 2] = fwd_sel;
    end

    always_comb begin
        src_hit = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (i_src_valid_id[k] && i_src_id[k*N_BITS_REG +: N_BITS_REG] == i_rd_ID_EX) begin
                src_hit = 1'b1;
            end
        end
    end

    assign load_use  = i_memRead_ID_EX && i_regWrite_ID_EX && (i_rd_ID_EX != '0) && src_hit;
    assign mem_stall = i_memAccess_EX_MEM && !i_mem_ready;

    // Once a freeze lifts, behave as whichever state it interrupted; a
    // non-zero load-use count means bubbles were still owed.
    assign active_state = (state == MEM_WAIT) ? ((lu_cnt != '0) ? LU_STALL : IDLE) : state;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            lu_cnt <= '0;
        end else begin
            state  <= state_next;
            lu_cnt <= lu_cnt_next;
        end
    end

    always_comb begin
        state_next  = active_state;
        lu_cnt_next = lu_cnt;
        if (mem_stall) begin
            state_next = MEM_WAIT;
        end else if (i_flush) begin
            state_next  = IDLE;
            lu_cnt_next = '0;
        end else begin
            case (active_state)
                LU_STALL: begin
                    lu_cnt_next = lu_cnt - CNT_W'(1);
                    if (lu_cnt == CNT_W'(1)) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    if (load_use && LOAD_LAT > 1) begin
                        state_next  = LU_STALL;
                        lu_cnt_next = CNT_W'(LOAD_LAT - 1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        o_freeze = 1'b0;
        o_stall  = 1'b0;
        o_bubble = 1'b0;
        if (!i_reset) begin
            if (mem_stall) begin
                o_freeze = 1'b1;
            end else if (!i_flush && (active_state == LU_STALL || load_use)) begin
                o_stall  = 1'b1;
                o_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        wait_next = '0;
        if (mem_stall) begin
            wait_next = (wait_cnt == WAIT_W'(MAX_WAIT)) ? wait_cnt : wait_cnt + WAIT_W'(1);
        end
    end

    // The timeout latches and stays set; the freeze itself keeps going.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wait_cnt       <= '0;
            o_mem_timeout  <= 1'b0;
            o_stall_cycles <= '0;
        end else begin
            wait_cnt <= wait_next;
            if (mem_stall && wait_next == WAIT_W'(MAX_WAIT)) begin
                o_mem_timeout <= 1'b1;
            end
            if ((o_stall || o_freeze) && o_stall_cycles != '1) begin
                o_stall_cycles <= o_stall_cycles + N_BITS_CNT'(1);
            end
        end
    end

endmodule
